// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/add_all.sv
// One-bit full adder used as the arithmetic cell of serial datapaths.
module add_all (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: latches two operands on start and adds them LSB first,
// one bit per clock, through a single full adder.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, cout_q, busy_q, done_q;
    logic               fa_sum, fa_carry;

    add_all u_fa (
        .sum   (fa_sum),
        .carry (fa_carry),
        .a     (a_q[cnt_q]),
        .b     (b_q[cnt_q]),
        .cin   (carry_q)
    );

    // Result register with the current bit written in place, so the exit
    // edge can publish the complete word in one step.
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        res_d        = res_q;
        res_d[cnt_q] = fa_sum;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments only; reset here is synchronous
        // and clears the whole datapath, which is small enough to be worth it.
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= fa_carry;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed scenarios, random operands
// against an arithmetic reference, and an exhaustive sweep at WIDTH=2.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // mode 0: start pulse; 1: start held through RUN; 2: operands change and
    // start pulses mid-RUN. tail: extra cycles watched after done.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input int mode, input int tail,
                        output logic [7:0] rs, output logic rc,
                        output int busy_n, output int done_n, output bit held);
        logic [7:0] s0;
        logic       c0;
        int         cyc;
        @(negedge clk);
        s0 = sum8; c0 = cout8;
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        if (mode != 1) start8 = 1'b0;
        busy_n = 0; done_n = 0; held = 1'b1; cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) busy_n++;
            if (sum8 !== s0 || cout8 !== c0) held = 1'b0;
            if (mode == 2 && busy_n == 3) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~tc; start8 = 1'b1;
            end else if (mode != 1) begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (done8 === 1'b1) done_n = 1;
        rs = sum8; rc = cout8;
        start8 = 1'b0;
        repeat (tail) begin
            @(negedge clk);
            if (done8 === 1'b1) done_n++;
            if (busy8 === 1'b1) busy_n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start8 = 1'b1; start2 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state8: busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
        end
        checks++;
        if ({busy2, done2, sum2, cout2} !== 5'd0) begin
            errors++;
            $display("FAIL reset_state2: busy=%b done=%b sum=%h cout=%b, required all 0", busy2, done2, sum2, cout2);
        end
        rst_n = 1'b1; start8 = 1'b0; start2 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b, required 0", busy8);
        end
    endtask

    task automatic test_basic;
        logic [7:0] s; logic c; int bn, dn; bit h;
        run8(8'h0F, 8'h01, 1'b0, 0, 3, s, c, bn, dn, h);
        checks++;
        if ({c, s} !== 9'h010) begin
            errors++; $display("FAIL basic_sum: got %h, required 010", {c, s});
        end
        checks++;
        if (bn !== 8) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d, required 8", bn);
        end
        checks++;
        if (dn !== 1) begin
            errors++; $display("FAIL basic_done_pulses: got %0d, required 1", dn);
        end
        checks++;
        if (h !== 1'b1) begin
            errors++; $display("FAIL basic_hold: sum/cout changed during RUN, required hold");
        end
    endtask

    task automatic test_all_ones;
        logic [7:0] s; logic c; int bn, dn; bit h;
        run8(8'hFF, 8'hFF, 1'b1, 0, 1, s, c, bn, dn, h);
        checks++;
        if ({c, s} !== 9'h1FF) begin
            errors++; $display("FAIL all_ones: got %h, required 1ff", {c, s});
        end
    endtask

    task automatic test_start_held;
        logic [7:0] s; logic c; int bn, dn; bit h;
        run8(8'h80, 8'h80, 1'b0, 1, 4, s, c, bn, dn, h);
        checks++;
        if ({c, s} !== 9'h100) begin
            errors++; $display("FAIL held_sum: got %h, required 100", {c, s});
        end
        checks++;
        if (dn !== 1 || bn !== 8) begin
            errors++; $display("FAIL held_pulses: done=%0d busy=%0d, required 1 and 8", dn, bn);
        end
    endtask

    task automatic test_input_change;
        logic [7:0] s; logic c; int bn, dn; bit h;
        run8(8'h12, 8'h34, 1'b0, 2, 3, s, c, bn, dn, h);
        checks++;
        if ({c, s} !== 9'h046) begin
            errors++; $display("FAIL input_change_sum: got %h, required 046", {c, s});
        end
        checks++;
        if (dn !== 1 || bn !== 8) begin
            errors++; $display("FAIL mid_start_ignored: done=%0d busy=%0d, required 1 and 8", dn, bn);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] s; logic c; int bn, dn, runs; bit h;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; runs = 0;
        while (runs < 4 && busy8 === 1'b1) begin
            runs++;
            if (runs < 4) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0 || runs != 4) begin
            errors++;
            $display("FAIL reset_mid_state: busy=%b done=%b sum=%h cout=%b runs=%0d, required 0 0 00 0 runs=4",
                     busy8, done8, sum8, cout8, runs);
        end
        rst_n = 1'b1; dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d pulses, required 0", dn);
        end
        run8(8'h01, 8'h01, 1'b0, 0, 1, s, c, bn, dn, h);
        checks++;
        if ({c, s} !== 9'h002) begin
            errors++; $display("FAIL reset_mid_restart: got %h, required 002", {c, s});
        end
    endtask

    task automatic test_random;
        logic [7:0] s, x, y; logic c, z; int bn, dn; bit h;
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom); y = 8'($urandom); z = 1'($urandom);
            run8(x, y, z, 0, 0, s, c, bn, dn, h);
            checks++;
            if ({c, s} !== ref8(x, y, z) || dn !== 1) begin
                errors++;
                $display("FAIL random_%0d: %h+%h+%b got %h done=%0d, required %h done=1",
                         i, x, y, z, {c, s}, dn, ref8(x, y, z));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s; logic c; int bn, dn; bit h;
        run8(8'hA5, 8'h5A, 1'b0, 0, 0, s, c, bn, dn, h);
        run8(8'hC3, 8'h4E, 1'b1, 0, 0, s, c, bn, dn, h);
        checks++;
        if ({c, s} !== ref8(8'hC3, 8'h4E, 1'b1) || bn !== 8) begin
            errors++;
            $display("FAIL back_to_back: got %h busy=%0d, required %h busy=8", {c, s}, bn, ref8(8'hC3, 8'h4E, 1'b1));
        end
    endtask

    task automatic test_exhaustive_w2;
        int cyc;
        logic [2:0] expected;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            a2 = 2'(k >> 3); b2 = 2'(k >> 1); cin2 = 1'(k);
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; cyc = 0;
            while (done2 !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            expected = 3'(k >> 3) + 3'((k >> 1) & 3) + 3'(k & 1);
            checks++;
            if (done2 !== 1'b1 || {cout2, sum2} !== expected) begin
                errors++;
                $display("FAIL w2_%0d: a=%0d b=%0d cin=%0d got %0d done=%b, required %0d",
                         k, k >> 3, (k >> 1) & 3, k & 1, {cout2, sum2}, done2, expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_start_held();
        test_input_change();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_exhaustive_w2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
